// File: rtl/hex_loader_pkg.sv
// Shared types and constants for the HEX/BIN ROM loader.
package hex_loader_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 16;

  localparam logic [7:0] REC_DATA    = 8'h00;
  localparam logic [7:0] REC_EOF     = 8'h01;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Intel HEX record parser states, one per character position
  typedef enum logic [3:0] {
    IDLE,
    CNT_H,
    CNT_L,
    ADR3,
    ADR2,
    ADR1,
    ADR0,
    TYP_H,
    TYP_L,
    DAT_H,
    DAT_L,
    CSM_H,
    CSM_L
  } hex_state_t;

endpackage

// File: rtl/hex_digit_dec.sv
// ASCII hex digit decoder: 0-9, A-F, a-f to a nibble plus a valid flag.
module hex_digit_dec (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  // Classify the character and strip its ASCII offset
  always_comb begin
    o_nibble = 4'h0;
    o_valid  = 1'b0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_nibble = 4'(i_byte - 8'h30);
      o_valid  = 1'b1;
    end else if (i_byte >= 8'h41 && i_byte <= 8'h46) begin
      o_nibble = 4'(i_byte - 8'h37);
      o_valid  = 1'b1;
    end else if (i_byte >= 8'h61 && i_byte <= 8'h66) begin
      o_nibble = 4'(i_byte - 8'h57);
      o_valid  = 1'b1;
    end
  end

endmodule

// File: rtl/hex_rom_loader.sv
// ROM loader for the AVR program store: raw BIN pass-through (index 0)
// or Intel HEX parsing (index != 0), with load status and CPU hold.
// Optional build macro HEX_CHECKSUM_EN adds record checksum verification.
module hex_rom_loader
  import hex_loader_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [14:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              rom_we,
  output logic [14:0]       rom_waddr,
  output logic [7:0]        rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       byte_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hex_state_t        r_state;
  hex_state_t        w_state_nxt;
  logic              r_dl_q;
  logic [7:0]        r_count;
  logic [7:0]        w_count_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        r_type;
  logic [7:0]        w_type_nxt;
  logic [3:0]        r_hi;
  logic [3:0]        w_hi_nxt;

  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_waddr;
  logic [7:0]        r_rom_wdata;
  logic              r_load_done;
  logic              r_load_err;
  logic              r_cpu_hold;
  logic [CNT_W-1:0]  r_byte_count;

  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [7:0]        w_wdata_nxt;
  logic              w_err_set;
  logic              w_done_set;

  logic              w_dl_rise;
  logic              w_dl_fall;
  logic              w_strobe;
  logic              w_hex_mode;
  logic              w_hex_step;
  logic [3:0]        w_nibble;
  logic              w_nib_valid;
  logic [7:0]        w_byte;

  // The edge cycles of ioctl_download are reserved for clearing/aborting
  assign w_dl_rise  = ioctl_download & ~r_dl_q;
  assign w_dl_fall  = ~ioctl_download & r_dl_q;
  assign w_strobe   = ioctl_download & ioctl_wr & ~w_dl_rise;
  assign w_hex_mode = (ioctl_index != 8'h00);
  assign w_hex_step = w_strobe & w_hex_mode & (r_state != IDLE) & w_nib_valid;
  assign w_byte     = {r_hi, w_nibble};

  hex_digit_dec u_dec (
    .i_byte   (ioctl_dout),
    .o_nibble (w_nibble),
    .o_valid  (w_nib_valid)
  );

`ifdef HEX_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_sum_add;

  assign w_sum_add = w_hex_step &
                     (r_state inside {CNT_L, ADR2, ADR0, TYP_L, DAT_L});

  // Running sum of record bytes, restarted at each record start
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sum <= 8'h00;
    end else if (w_strobe && w_hex_mode && r_state == IDLE) begin
      r_sum <= 8'h00;
    end else if (w_sum_add) begin
      r_sum <= 8'(r_sum + w_byte);
    end
  end
`endif

  // Parser state and record fields
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 8'h00;
      r_addr  <= '0;
      r_type  <= 8'h00;
      r_hi    <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_addr  <= w_addr_nxt;
      r_type  <= w_type_nxt;
      r_hi    <= w_hi_nxt;
    end
  end

  // Next-state, record field updates and write/flag requests
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    w_type_nxt  = r_type;
    w_hi_nxt    = r_hi;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_rom_waddr;
    w_wdata_nxt = r_rom_wdata;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;

    if (w_dl_rise) begin
      w_state_nxt = IDLE;
    end else if (w_dl_fall) begin
      if (r_state != IDLE) w_err_set = 1'b1;
      w_state_nxt = IDLE;
    end else if (w_strobe && !w_hex_mode) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = ioctl_addr;
      w_wdata_nxt = ioctl_dout;
    end else if (w_strobe) begin
      if (r_state == IDLE) begin
        if (ioctl_dout == ASCII_COLON) w_state_nxt = CNT_H;
      end else if (!w_nib_valid) begin
        w_err_set   = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        case (r_state)
          CNT_H: begin
            w_hi_nxt    = w_nibble;
            w_state_nxt = CNT_L;
          end
          CNT_L: begin
            w_count_nxt = w_byte;
            w_state_nxt = ADR3;
          end
          ADR3: begin
            w_hi_nxt    = w_nibble;
            w_addr_nxt  = {w_nibble[2:0], r_addr[11:0]};
            w_state_nxt = ADR2;
          end
          ADR2: begin
            w_addr_nxt[11:8] = w_nibble;
            w_state_nxt      = ADR1;
          end
          ADR1: begin
            w_hi_nxt        = w_nibble;
            w_addr_nxt[7:4] = w_nibble;
            w_state_nxt     = ADR0;
          end
          ADR0: begin
            w_addr_nxt[3:0] = w_nibble;
            w_state_nxt     = TYP_H;
          end
          TYP_H: begin
            w_hi_nxt    = w_nibble;
            w_state_nxt = TYP_L;
          end
          TYP_L: begin
            w_type_nxt  = w_byte;
            w_state_nxt = (r_count == 8'h00 || w_byte != REC_DATA) ? CSM_H : DAT_H;
          end
          DAT_H: begin
            w_hi_nxt    = w_nibble;
            w_state_nxt = DAT_L;
          end
          DAT_L: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_addr;
            w_wdata_nxt = w_byte;
            w_addr_nxt  = ADDR_W'(r_addr + ADDR_W'(1));
            w_count_nxt = 8'(r_count - 8'd1);
            w_state_nxt = (r_count == 8'd1) ? CSM_H : DAT_H;
          end
          CSM_H: begin
            w_hi_nxt    = w_nibble;
            w_state_nxt = CSM_L;
          end
          CSM_L: begin
            w_state_nxt = IDLE;
            if (r_type == REC_EOF) w_done_set = 1'b1;
`ifdef HEX_CHECKSUM_EN
            if (8'(r_sum + w_byte) != 8'h00) w_err_set = 1'b1;
`endif
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  // Registered ROM write port, status flags and byte counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_q       <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_waddr  <= '0;
      r_rom_wdata  <= 8'h00;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_byte_count <= '0;
    end else begin
      r_dl_q      <= ioctl_download;
      r_rom_we    <= w_we_nxt;
      r_rom_waddr <= w_waddr_nxt;
      r_rom_wdata <= w_wdata_nxt;
      r_cpu_hold  <= ioctl_download | (~w_dl_rise & (r_load_err | w_err_set));
      if (w_dl_rise) begin
        r_load_done  <= 1'b0;
        r_load_err   <= 1'b0;
        r_byte_count <= '0;
      end else begin
        if (w_done_set) r_load_done <= 1'b1;
        if (w_err_set)  r_load_err  <= 1'b1;
        if (w_we_nxt && r_byte_count != CNT_MAX) begin
          r_byte_count <= CNT_W'(r_byte_count + CNT_W'(1));
        end
      end
    end
  end

  assign rom_we     = r_rom_we;
  assign rom_waddr  = r_rom_waddr;
  assign rom_wdata  = r_rom_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_hex_rom_loader.sv
// Randomized bench for hex_rom_loader with a record-level reference model.
module tb_hex_rom_loader;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [14:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_we;
  logic [14:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] byte_count;

  hex_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rom_we         (rom_we),
    .rom_waddr      (rom_waddr),
    .rom_wdata      (rom_wdata),
    .cpu_hold       (cpu_hold),
    .load_done      (load_done),
    .load_err       (load_err),
    .byte_count     (byte_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

`ifdef HEX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit  m_started = 0;
  bit  m_dl_q    = 0;
  bit  m_in_rec  = 0;
  bit  m_have_hi = 0;
  int  m_hi      = 0;
  int  m_bytes[$];
  int  m_sum     = 0;
  int  m_ndata   = 0;
  bit  e_rst     = 0;
  bit  e_we      = 0;
  int  e_waddr   = 0;
  int  e_wdata   = 0;
  bit  e_done    = 0;
  bit  e_err     = 0;
  int  e_cnt     = 0;
  bit  e_hold    = 1;

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  task automatic m_write(input int a, input int d);
    e_we    = 1;
    e_waddr = a & 32'h7FFF;
    e_wdata = d & 32'hFF;
    if (e_cnt < 65535) e_cnt++;
  endtask

  // A record is ':' followed by byte fields: count, addr hi, addr lo, type,
  // data (only for type 00), checksum; sum of all bytes must be 0 mod 256.
  task automatic m_hex_char(input logic [7:0] b);
    int v, k, bv;
    if (!m_in_rec) begin
      if (b == 8'h3A) begin
        m_in_rec  = 1;
        m_have_hi = 0;
        m_sum     = 0;
        m_bytes.delete();
      end
      return;
    end
    v = hexval(b);
    if (v < 0) begin
      e_err    = 1;
      m_in_rec = 0;
      return;
    end
    if (!m_have_hi) begin
      m_hi      = v;
      m_have_hi = 1;
      return;
    end
    m_have_hi = 0;
    bv = m_hi * 16 + v;
    k  = m_bytes.size();
    m_bytes.push_back(bv);
    m_sum = (m_sum + bv) % 256;
    if (k == 3) m_ndata = (bv == 0) ? m_bytes[0] : 0;
    if (k >= 4 && k < 4 + m_ndata) begin
      m_write(m_bytes[1] * 256 + m_bytes[2] + (k - 4), bv);
    end else if (k >= 4 && k == 4 + m_ndata) begin
      m_in_rec = 0;
      if (m_bytes[3] == 1) e_done = 1;
      if (CSUM_EN && m_sum != 0) e_err = 1;
    end
  endtask

  always @(posedge clk_sys) begin
    m_started = 1;
    e_we  = 0;
    e_rst = 0;
    if (reset) begin
      e_rst = 1; e_waddr = 0; e_wdata = 0; e_done = 0; e_err = 0;
      e_cnt = 0; e_hold = 1; m_in_rec = 0; m_dl_q = 0;
    end else begin
      if (ioctl_download && !m_dl_q) begin
        e_done = 0; e_err = 0; e_cnt = 0; m_in_rec = 0;
      end else if (!ioctl_download && m_dl_q) begin
        if (m_in_rec) e_err = 1;
        m_in_rec = 0;
      end else if (ioctl_download && ioctl_wr) begin
        if (ioctl_index == 8'h00) m_write(int'(ioctl_addr), int'(ioctl_dout));
        else m_hex_char(ioctl_dout);
      end
      e_hold = ioctl_download | e_err;
      m_dl_q = ioctl_download;
    end
  end

  // ---------------- per-cycle compare ----------------
  int wlog[$];

  always @(negedge clk_sys) begin
    if (m_started) begin
      chk("rom_we", 32'(rom_we), 32'(e_we));
      if (e_we || e_rst) begin
        chk("rom_waddr", 32'(rom_waddr), 32'(e_waddr));
        chk("rom_wdata", 32'(rom_wdata), 32'(e_wdata));
      end
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("load_err", 32'(load_err), 32'(e_err));
      chk("byte_count", 32'(byte_count), 32'(e_cnt));
      chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      if (rom_we === 1'b1) wlog.push_back({int'(rom_waddr), 8'h00} | int'(rom_wdata));
    end
  end

  function automatic int log_at(input int i);
    if (wlog.size() > i) return wlog[i];
    return 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic strobe(input logic [7:0] b, input logic [14:0] a);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    idle($urandom_range(0, 2));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) strobe(s[i], 15'($urandom));
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    idle(2);
  endtask

  task automatic end_dl();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    idle(3);
  endtask

  function automatic string mk_rec(input int cnt, input int a16, input int typ,
                                   input bit bad, input bit lower);
    string r;
    int s, d, cs;
    r = $sformatf(":%02X%04X%02X", cnt, a16, typ);
    s = cnt + (a16 >> 8) + (a16 & 255) + typ;
    for (int i = 0; i < cnt; i++) begin
      d = int'($urandom_range(0, 255));
      s += d;
      r = {r, $sformatf("%02X", d)};
    end
    cs = (256 - (s % 256)) % 256;
    if (bad) cs = (cs + 1) % 256;
    r = {r, $sformatf("%02X", cs)};
    if (lower) r = r.tolower();
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int a16, typ, cnt, choice;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_addr     = 15'h0;
    ioctl_dout     = 8'h00;
    idle(2);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(rom_we), 32'd0);
    chk("rst_cnt", 32'(byte_count), 32'd0);
    reset = 1'b0;
    idle(2);

    // BIN pass-through
    wlog.delete();
    start_dl(8'h00);
    strobe(8'hAA, 15'h0000);
    strobe(8'h55, 15'h0001);
    idle(2);
    chk("bin_w0", 32'(log_at(0)), 32'h0000AA);
    chk("bin_w1", 32'(log_at(1)), 32'h000155);
    chk("bin_count", 32'(byte_count), 32'd2);
    end_dl();

    // HEX data + EOF
    wlog.delete();
    start_dl(8'h01);
    send_str(":0200100012AB31\r\n:00000001FF");
    idle(2);
    chk("hex_w0", 32'(log_at(0)), 32'h001012);
    chk("hex_w1", 32'(log_at(1)), 32'h0011AB);
    chk("hex_done", 32'(load_done), 32'd1);
    chk("hex_err", 32'(load_err), 32'd0);
    end_dl();
    chk("hex_hold", 32'(cpu_hold), 32'd0);

    // Space inside a record
    wlog.delete();
    start_dl(8'h01);
    send_str(":020010001 2ab31");
    idle(2);
    chk("sp_err", 32'(load_err), 32'd1);
    chk("sp_nwr", 32'(wlog.size()), 32'd0);
    end_dl();
    chk("sp_hold", 32'(cpu_hold), 32'd1);

    // Bad checksum
    wlog.delete();
    start_dl(8'h01);
    send_str(":0100000042BE");
    idle(2);
    chk("cs_w0", 32'(log_at(0)), 32'h000042);
    chk("cs_err", 32'(load_err), CSUM_EN ? 32'd1 : 32'd0);
    end_dl();

    // Address wrap
    wlog.delete();
    start_dl(8'h01);
    send_str(":027FFF00A1B22D");
    idle(2);
    chk("wrap_w0", 32'(log_at(0)), 32'h7FFFA1);
    chk("wrap_w1", 32'(log_at(1)), 32'h0000B2);
    chk("wrap_err", 32'(load_err), 32'd0);
    end_dl();

    // Truncated record
    start_dl(8'h01);
    send_str(":0400");
    end_dl();
    chk("trunc_err", 32'(load_err), 32'd1);
    chk("trunc_hold", 32'(cpu_hold), 32'd1);

    // Reset in the middle of data
    wlog.delete();
    start_dl(8'h01);
    send_str(":03000000AAB");
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    send_str("BCC");
    idle(2);
    chk("rmid_nwr", 32'(wlog.size()), 32'd1);
    chk("rmid_err", 32'(load_err), 32'd0);
    chk("rmid_cnt", 32'(byte_count), 32'd0);
    end_dl();
    chk("rmid_hold", 32'(cpu_hold), 32'd0);

    // Randomized HEX files and BIN bursts
    for (int f = 0; f < 10; f++) begin
      if (f % 3 == 2) begin
        start_dl(8'h00);
        for (int i = 0; i < 16; i++) strobe(8'($urandom), 15'($urandom));
        end_dl();
        continue;
      end
      start_dl(8'($urandom_range(1, 255)));
      for (int r = 0; r < 6; r++) begin
        choice = int'($urandom_range(0, 19));
        case ($urandom_range(0, 2))
          0: send_str("\r\n");
          1: send_str(" ");
          default: ;
        endcase
        if (choice == 0) begin
          send_str(":0G");
        end else if (choice == 1) begin
          send_str(mk_rec(3, 16'h1234, 0, 0, 0).substr(0, 8));
          break;
        end else begin
          typ = (choice < 16) ? 0 : int'($urandom_range(2, 5));
          cnt = (typ == 0) ? int'($urandom_range(0, 4)) : 0;
          a16 = (choice == 2) ? 16'hFFFE : int'($urandom_range(0, 65535));
          send_str(mk_rec(cnt, a16, typ, ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 1) == 1)));
        end
      end
      if ($urandom_range(0, 1) == 1) send_str("\r\n:00000001FF");
      end_dl();
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_rom_loader.md
HEX_ROM_LOADER -- requirements
Module: hex_rom_loader

Interface
REQ-001 SHALL have ports: clk_sys  in  1  system clock, sole clock domain.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ioctl_download  in  1  download active; ioctl_wr  in  1  byte strobe; ioctl_index  in  8  0 = raw BIN, nonzero = Intel HEX; ioctl_addr  in  15  byte address; ioctl_dout  in  8  byte data.
REQ-004 SHALL have ports: rom_we  out  1  ROM byte-write pulse; rom_waddr  out  15  byte address (bit 0 selects word half); rom_wdata  out  8  byte.
REQ-005 SHALL have ports: cpu_hold  out  1  hold AVR in reset; load_done  out  1  EOF record seen; load_err  out  1  sticky parse or checksum error; byte_count  out  16  bytes written in the current load.

Function
REQ-006 BIN mode (ioctl_index == 0) SHALL pulse rom_we exactly one clk_sys after each ioctl_wr, with rom_waddr = ioctl_addr and rom_wdata = ioctl_dout.
REQ-007 HEX mode SHALL use FSM states IDLE, CNT_H, CNT_L, ADR3, ADR2, ADR1, ADR0, TYP_H, TYP_L, DAT_H, DAT_L, CSM_H, CSM_L; each state SHALL advance only on ioctl_wr.
REQ-008 In IDLE, ':' SHALL go to CNT_H; any other byte (CR, LF, space) SHALL be ignored.
REQ-009 Hex digits SHALL be accepted as 0-9, A-F and a-f; any other byte outside IDLE SHALL set load_err and return to IDLE.
REQ-010 After TYP_L: count 0 or type != 00 SHALL go to CSM_H; otherwise it SHALL go to DAT_H.
REQ-011 Each DAT_L with type 00 SHALL pulse rom_we one cycle later with the current address, then increment the address modulo 2^15 (0x7FFF wraps to 0x0000).
REQ-012 DAT_L SHALL decrement the remaining count; count reaching 0 SHALL go to CSM_H, otherwise it SHALL go to DAT_H.
REQ-013 CSM_L SHALL return to IDLE; type 01 SHALL set load_done; types 02-05 SHALL be ignored without error.
REQ-014 byte_count SHALL increment on every rom_we in both modes and saturate at 0xFFFF.
REQ-015 A rising edge of ioctl_download SHALL clear load_done, load_err and byte_count and force IDLE.
REQ-016 A falling edge of ioctl_download with HEX FSM not in IDLE SHALL set load_err and force IDLE (truncated record).
REQ-017 cpu_hold SHALL be 1 while ioctl_download = 1, and SHALL equal load_err afterwards (an error keeps the CPU held until the next download).
REQ-018 ioctl_wr while ioctl_download = 0 SHALL be ignored.

Reset
REQ-019 Reset SHALL force IDLE, rom_we = 0, rom_waddr = 0, rom_wdata = 0, load_done = 0, load_err = 0, byte_count = 0 and cpu_hold = 1 for the reset cycle.
REQ-020 Reset asserted mid-record SHALL abort the record with no further rom_we.

Configuration
REQ-021 Macro HEX_CHECKSUM_EN defined: an 8-bit running sum of all record bytes (count through checksum) SHALL be kept, and a nonzero sum at CSM_L SHALL set load_err.
REQ-022 Macro HEX_CHECKSUM_EN undefined: the checksum digits SHALL be parsed for syntax only, with no sum logic.
REQ-023 Data writes SHALL occur identically in both builds; a checksum failure SHALL NOT retract bytes already written.

Structure
REQ-024 Package hex_loader_pkg SHALL hold the FSM state enum, record-type constants (REC_DATA = 8'h00, REC_EOF = 8'h01) and ASCII_COLON.
REQ-025 Sub-module hex_digit_dec SHALL be combinational, with input byte, outputs nibble[3:0] and valid.

Verification
REQ-026 BIN: index 0, bytes 0xAA at address 0x0000 and 0x55 at 0x0001 SHALL give two rom_we pulses, each one cycle after its strobe, and byte_count = 2.
REQ-027 HEX: ":0200100012AB31\r\n:00000001FF" SHALL write 0x12 at 0x0010 and 0xAB at 0x0011, then set load_done = 1 with load_err = 0.
REQ-028 HEX: lowercase ":020010001 2ab31" with the space inside the record SHALL set load_err, give no further rom_we, and keep cpu_hold = 1 after the download ends.
REQ-029 HEX_CHECKSUM_EN build: ":0100000042BE" (bad sum) SHALL write 0x42 at 0x0000 and set load_err; the same stimulus without the macro SHALL leave load_err = 0.
REQ-030 Wrap: ":027FFF00A1B2xx" (xx = valid checksum) SHALL write 0xA1 at 0x7FFF and 0xB2 at 0x0000.
REQ-031 Download dropped after ":0400" SHALL set load_err; reset asserted mid-DAT SHALL clear all flags and give no further rom_we.
